// File: rtl/crc8_serial.sv
// Serial CRC-8: absorbs Data LSB-first while Active, then shifts CRC out LSB-first with Valid for WIDTH cycles.
// First CRC bit on the first edge with Active low; no backpressure. CRC_PAR_OUT_EN adds a parallel capture port.
module crc8_serial #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = 8'hD8,
  parameter logic [WIDTH-1:0] TAPS  = 8'b01000100
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Active,
  input  logic             Data,
`ifdef CRC_PAR_OUT_EN
  output logic [WIDTH-1:0] Crc_Par,
  output logic             Crc_Par_Valid,
`endif
  output logic             CRC,
  output logic             Valid
);

  localparam int             CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_END = CW'(WIDTH);
  // Stage WIDTH-1 always takes plain feedback, so its tap bit is ignored.
  localparam logic [WIDTH-1:0] TAP_LO = {1'b0, TAPS[WIDTH-2:0]};

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             crc_q, crc_d;
  logic             valid_q, valid_d;
  logic             fb;

  assign fb = Data ^ lfsr_q[0];

  always_comb begin
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    crc_d   = 1'b0;
    valid_d = 1'b0;
    if (Active) begin
      lfsr_d = {fb, lfsr_q[WIDTH-1:1]} ^ (TAP_LO & {WIDTH{fb}});
      cnt_d  = '0;
    end else if (cnt_q < CNT_END) begin
      crc_d   = lfsr_q[0];
      lfsr_d  = {1'b0, lfsr_q[WIDTH-1:1]};
      valid_d = 1'b1;
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      crc_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      valid_q <= valid_d;
    end
  end

  assign CRC   = crc_q;
  assign Valid = valid_q;

`ifdef CRC_PAR_OUT_EN
  logic             act_q;
  logic             cap;
  logic [WIDTH-1:0] par_q;
  logic             par_vld_q;

  // Capture the pre-shift LFSR on the Active falling edge, in step with the first serial bit.
  assign cap = act_q & ~Active;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      act_q     <= 1'b0;
      par_q     <= '0;
      par_vld_q <= 1'b0;
    end else begin
      act_q     <= Active;
      par_vld_q <= cap;
      if (cap) par_q <= lfsr_q;
    end
  end

  assign Crc_Par       = par_q;
  assign Crc_Par_Valid = par_vld_q;
`endif

endmodule

// File: tb/tb_crc8_serial.sv
// Randomized bench for crc8_serial against a polynomial-form reference of the CRC register.
module tb_crc8_serial;

  localparam logic [7:0] SEED = 8'hD8;
  localparam logic [7:0] TAPS = 8'b01000100;
  // Right-shifting Galois form: feedback enters the top bit plus every tapped lower stage.
  localparam logic [7:0] POLY = 8'h80 | (TAPS & 8'h7F);

  logic CLK = 1'b0;
  logic RST, Active, Data;
  logic CRC, Valid;
`ifdef CRC_PAR_OUT_EN
  logic [7:0] Crc_Par;
  logic       Crc_Par_Valid;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] m_lfsr;

  always #5 CLK = ~CLK;

  crc8_serial dut (
    .CLK          (CLK),
    .RST          (RST),
    .Active       (Active),
    .Data         (Data),
`ifdef CRC_PAR_OUT_EN
    .Crc_Par      (Crc_Par),
    .Crc_Par_Valid(Crc_Par_Valid),
`endif
    .CRC          (CRC),
    .Valid        (Valid)
  );

  function automatic logic [7:0] ref_absorb(input logic [7:0] l, input logic d);
    return (l >> 1) ^ (((l[0] ^ d) == 1'b1) ? POLY : 8'h00);
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic act);
    Active = act;
    Data   = 1'b0;
    RST    = 1'b1;
    #2;
    tick;
    RST    = 1'b0;
    m_lfsr = SEED;
  endtask

  task automatic absorb_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      Active = 1'b1;
      Data   = w[i];
      tick;
      m_lfsr = ref_absorb(m_lfsr, w[i]);
    end
  endtask

  // Gathers eight shift-out cycles plus one trailing cycle; Data is noise since Active is low.
  task automatic collect(output logic [7:0] word, output logic [7:0] vmask, output logic tail_vld);
    Active = 1'b0;
    word   = '0;
    vmask  = '0;
    for (int k = 0; k < 8; k++) begin
      Data = 1'($urandom);
      tick;
      word[k]  = CRC;
      vmask[k] = Valid;
    end
    tick;
    tail_vld = Valid;
  endtask

  task automatic test_reset;
    logic [7:0] w, vm;
    logic tl;
    Active = 1'b0;
    Data   = 1'b0;
    RST    = 1'b1;
    #1;
    n_cmp++;
    if (Valid !== 1'b0 || CRC !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: Valid=%b CRC=%b, required 0 0", Valid, CRC);
    end
    tick;
    RST    = 1'b0;
    m_lfsr = SEED;
    collect(w, vm, tl);
    n_cmp++;
    if (w !== SEED) begin
      n_fail++;
      $display("FAIL reset_seed_word: got %h, required %h", w, SEED);
    end
    n_cmp++;
    if (vm !== 8'hFF || tl !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_seed_valid: mask=%h tail=%b, required ff 0", vm, tl);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++;
      if (Valid !== 1'b0 || CRC !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: Valid=%b CRC=%b, required 0 0", Valid, CRC);
      end
    end
  endtask

  task automatic test_zero_msg;
    logic [7:0] w, vm;
    do_reset(1'b1);
    absorb_bits(8'h00, 8);
    Active = 1'b0;
    w  = '0;
    vm = '0;
    for (int k = 0; k < 8; k++) begin
      tick;
      w[k]  = CRC;
      vm[k] = Valid;
`ifdef CRC_PAR_OUT_EN
      n_cmp++;
      if (Crc_Par_Valid !== (k == 0) || (k == 0 && Crc_Par !== 8'h14)) begin
        n_fail++;
        $display("FAIL zero_par cycle %0d: par=%h pv=%b, required 14 %b", k, Crc_Par, Crc_Par_Valid, k == 0);
      end
`endif
    end
    n_cmp++;
    if (w !== 8'h14 || vm !== 8'hFF) begin
      n_fail++;
      $display("FAIL zero_msg: word=%h mask=%h, required 14 ff", w, vm);
    end
    tick;
    n_cmp++;
    if (Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_tail: Valid=%b, required 0", Valid);
    end
`ifdef CRC_PAR_OUT_EN
    n_cmp++;
    if (Crc_Par !== 8'h14 || Crc_Par_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_par_hold: par=%h pv=%b, required 14 0", Crc_Par, Crc_Par_Valid);
    end
`endif
    m_lfsr = 8'h00;
  endtask

  task automatic test_random_words;
    logic [7:0] din, exp, w, vm;
    logic tl;
    for (int n = 0; n < 10; n++) begin
      din = 8'($urandom);
      do_reset(1'b1);
      absorb_bits(din, 8);
      exp = m_lfsr;
      collect(w, vm, tl);
      m_lfsr = 8'h00;
      n_cmp++;
      if (w !== exp) begin
        n_fail++;
        $display("FAIL random_word din=%h: got %h, required %h", din, w, exp);
      end
      n_cmp++;
      if (vm !== 8'hFF || tl !== 1'b0) begin
        n_fail++;
        $display("FAIL random_valid din=%h: mask=%h tail=%b, required ff 0", din, vm, tl);
      end
`ifdef CRC_PAR_OUT_EN
      n_cmp++;
      if (Crc_Par !== exp) begin
        n_fail++;
        $display("FAIL random_par din=%h: got %h, required %h", din, Crc_Par, exp);
      end
`endif
    end
  endtask

  task automatic test_async_reset;
    logic [7:0] w, vm;
    logic tl;
    // Reset pulsed between edges while absorbing.
    do_reset(1'b1);
    absorb_bits(8'($urandom), 5);
    #2 RST = 1'b1;
    #1;
    n_cmp++;
    if (Valid !== 1'b0 || CRC !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_absorb_now: Valid=%b CRC=%b, required 0 0", Valid, CRC);
    end
    #1 RST = 1'b0;
    collect(w, vm, tl);
    n_cmp++;
    if (w !== SEED || vm !== 8'hFF) begin
      n_fail++;
      $display("FAIL arst_absorb_seed: word=%h mask=%h, required %h ff", w, vm, SEED);
    end
    // Reset pulsed between edges while Valid is high.
    do_reset(1'b1);
    absorb_bits(8'($urandom), 8);
    Active = 1'b0;
    tick;
    tick;
    n_cmp++;
    if (Valid !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre_valid: Valid=%b, required 1", Valid);
    end
    #2 RST = 1'b1;
    #1;
    n_cmp++;
    if (Valid !== 1'b0 || CRC !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_shift_now: Valid=%b CRC=%b, required 0 0", Valid, CRC);
    end
    #1 RST = 1'b0;
    collect(w, vm, tl);
    n_cmp++;
    if (w !== SEED || vm !== 8'hFF || tl !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_shift_seed: word=%h mask=%h tail=%b, required %h ff 0", w, vm, tl, SEED);
    end
    m_lfsr = 8'h00;
  endtask

  task automatic test_abort;
    logic [7:0] w1, w2, exp, w, vm, part;
    logic tl;
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    do_reset(1'b1);
    absorb_bits(w1, 8);
    exp    = m_lfsr;
    Active = 1'b0;
    part   = '0;
    for (int k = 0; k < 3; k++) begin
      tick;
      part[k] = CRC & Valid;
    end
    n_cmp++;
    if (part[2:0] !== exp[2:0]) begin
      n_fail++;
      $display("FAIL abort_partial: got %b, required %b", part[2:0], exp[2:0]);
    end
    m_lfsr = m_lfsr >> 3;
    Active = 1'b1;
    Data   = w2[0];
    tick;
    m_lfsr = ref_absorb(m_lfsr, w2[0]);
    n_cmp++;
    if (Valid !== 1'b0 || CRC !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_edge: Valid=%b CRC=%b, required 0 0", Valid, CRC);
    end
    absorb_bits(w2 >> 1, 7);
    exp = m_lfsr;
    collect(w, vm, tl);
    m_lfsr = 8'h00;
    n_cmp++;
    if (w !== exp || vm !== 8'hFF || tl !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_resume: word=%h mask=%h tail=%b, required %h ff 0", w, vm, tl, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] din, exp, w, vm;
    logic tl;
    int lens[3] = '{8, 1, 20};
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < lens[m]; i++) begin
        din = 8'($urandom);
        absorb_bits(din, 1);
      end
      exp = m_lfsr;
      collect(w, vm, tl);
      m_lfsr = 8'h00;
      n_cmp++;
      if (w !== exp || vm !== 8'hFF || tl !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b len %0d: word=%h mask=%h tail=%b, required %h ff 0", lens[m], w, vm, tl, exp);
      end
      // Zero-length message: staying idle produces no further Valid burst.
      for (int i = 0; i < 4; i++) begin
        Data = 1'($urandom);
        tick;
        n_cmp++;
        if (Valid !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_idle len %0d: Valid=%b, required 0", lens[m], Valid);
        end
      end
    end
  endtask

  initial begin
    RST    = 1'b0;
    Active = 1'b0;
    Data   = 1'b0;
    m_lfsr = SEED;
    test_reset;
    test_zero_msg;
    test_random_words;
    test_async_reset;
    test_abort;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/crc8_serial.md
Name: crc8_serial

Overview:
- Serial CRC-8 generator built on an 8-bit LFSR with a fixed seed and fixed taps.
- While Active is high, it absorbs one data bit per clock, LSB of the data word first.
- When Active falls, it shifts the 8-bit CRC out serially, LSB first, on CRC, with Valid high for exactly WIDTH cycles.
- Sits on a bit-serial link, between the transmit serializer and the line interface.

Parameters:
- WIDTH, 8: LFSR / CRC width in bits; also the number of output bits.
- SEED, 8'hD8: LFSR load value on reset.
- TAPS, 8'b01000100: feedback tap mask; bit i set means stage i receives XOR feedback.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- Active  input  1  high = absorb Data this cycle; falling edge starts CRC shift-out.
- Data  input  1  serial message bit, sampled on rising CLK while Active = 1.
- CRC  output  1  registered serial CRC bit, meaningful only while Valid = 1.
- Valid  output  1  registered; high while a CRC bit is being presented.

Behaviour:
- Reset (RST = 1, asynchronous): LFSR <= SEED, CRC <= 0, Valid <= 0, bit counter <= 0. Dominates all other inputs.
- State: LFSR[WIDTH-1:0] plus a shift-out counter of width clog2(WIDTH+1).
- Absorb (Active = 1 at a rising edge):
  - fb = Data ^ LFSR[0].
  - LFSR[WIDTH-1] <= fb.
  - For i < WIDTH-1: LFSR[i] <= TAPS[i] ? (LFSR[i+1] ^ fb) : LFSR[i+1].
  - Counter <= 0; Valid <= 0; CRC <= 0.
- Shift-out (Active = 0 and counter < WIDTH at a rising edge):
  - CRC <= LFSR[0]; LFSR <= {1'b0, LFSR[WIDTH-1:1]}; Valid <= 1; counter <= counter + 1.
- Idle (Active = 0 and counter == WIDTH): Valid <= 0, CRC <= 0, LFSR holds.
- Latency: the first CRC bit appears on the first rising edge with Active = 0 after absorption. Bit k of the CRC word is valid in the k-th Valid cycle. No gap between bits.
- The LFSR is not re-seeded by Active. Only RST loads SEED. Consecutive messages without an intervening reset continue from the current (shifted-out, zero) LFSR contents.
- Active reasserted during shift-out: the shift-out aborts immediately, Valid drops on that edge, and absorption resumes from the partially shifted LFSR.
- After reset with Active low, the block shifts out SEED (LSB first) for WIDTH cycles. Users must hold Active high in the first cycle after reset, or ignore that Valid burst.
- Message length is unconstrained. Any number of Active cycles is allowed, including zero.

Optional Feature:
- Macro: CRC_PAR_OUT_EN.
- Defined:
  - Adds output Crc_Par [WIDTH-1:0] and a 1-bit output Crc_Par_Valid.
  - On the first rising edge with Active = 0 following an Active = 1 cycle, Crc_Par captures the full LFSR and Crc_Par_Valid pulses high for one cycle.
  - Crc_Par holds its value until the next capture; reset value is 0.
- Undefined: neither port exists, and the serial behaviour is identical.

Test Plan:
- Reset then idle: assert RST, release with Active = 0 -> Valid high for 8 cycles with CRC bits 0,0,0,1,1,0,1,1 (SEED 0xD8, LSB first), then Valid = 0.
- Zero message: reset, Active = 1 for 8 cycles with Data = 0 -> 8 Valid cycles; the collected bits form word 0x14 (serial 0,0,1,0,1,0,0,0).
- Random words: for ten 8-bit words, reset, feed LSB first, collect 8 CRC bits into bit positions 0..7 -> matches a reference model of the Behaviour equations; Valid is exactly 8 cycles, contiguous.
- Async reset mid-message: pulse RST between clock edges during absorb -> LFSR = 0xD8 and Valid = 0 immediately, without waiting for a clock edge.
- Abort: reassert Active after 3 shifted bits -> Valid = 0 on that edge; after a further 8-bit absorb and Active low, 8 new Valid cycles follow.
- With CRC_PAR_OUT_EN: the zero-message case gives Crc_Par = 0x14 with a single-cycle Crc_Par_Valid pulse aligned with the first serial bit.
